// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmit frame sequencer (start, data LSB-first, optional
//            parity, stop), one line bit per CLK cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [c_CNT_W-1:0]      w_cnt_inc;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_tx;
    logic                    w_tx_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    w_load;
    logic                    w_parity;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;
    // Odd parity is the complement of the even (XOR) parity.
    assign w_parity  = (^r_data) ^ r_par_typ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            if (w_load) begin
                r_data    <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (DATA_VALID) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = '0;
                w_tx_nxt    = r_data[0];
            end
            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    if (r_par_en) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = w_parity;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_tx_nxt  = r_data[w_cnt_inc];
                end
            end
            S_PARITY: begin
                w_state_nxt = S_STOP;
                w_tx_nxt    = 1'b1;
            end
            S_STOP: begin
                // A request on the final stop cycle chains the next frame with no idle gap.
                if (DATA_VALID) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Brief    : Directed self-checking bench for uart_tx_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is accepted on the next rising edge.
    // Afterwards the live inputs are scrambled so only latched copies can matter.
    task automatic start_req(input logic [7:0] d, input logic pe, input logic pt, input bit hold);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) DATA_VALID = 1'b0;
        P_DATA  = ~d;
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
    endtask

    // exp[k] is the TX level after edge e_k. Optionally inject a request
    // after checking bit inj_k; optionally check the return to idle.
    task automatic check_frame(input string tag, input logic [15:0] exp, input int len,
                               input int inj_k, input logic [7:0] inj_d, input bit chk_idle);
        for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            check($sformatf("%s_tx%0d", tag, k), 32'(TX_OUT), 32'(exp[k]));
            check($sformatf("%s_busy%0d", tag, k), 32'(Busy), 32'd1);
            if (k == inj_k) begin
                P_DATA     = inj_d;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b0;
                DATA_VALID = 1'b1;
                @(posedge CLK);
                #1;
                DATA_VALID = 1'b0;
            end
        end
        if (chk_idle) begin
            @(negedge CLK);
            check({tag, "_idle_tx"}, 32'(TX_OUT), 32'd1);
            check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
        end
    endtask

    initial begin
        RST        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #1;
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);

        // Request on the very first edge after reset release.
        @(negedge CLK);
        RST = 1'b0;
        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
        start_req(8'hA5, 1'b1, 1'b0, 1'b0);
        check_frame("a5_even", 16'h054A, 11, -1, 8'h00, 1'b1);

        // 0xA5 odd parity: parity cycle flips to 1
        start_req(8'hA5, 1'b1, 1'b1, 1'b0);
        check_frame("a5_odd", 16'h074A, 11, -1, 8'h00, 1'b1);

        // 0x01 no parity: 0,1,0,0,0,0,0,0,0,1
        start_req(8'h01, 1'b0, 1'b0, 1'b0);
        check_frame("x01_nopar", 16'h0202, 10, -1, 8'h00, 1'b1);

        // Back-to-back: 0x3C with DATA_VALID held, 0xFF presented on stop cycle
        start_req(8'h3C, 1'b0, 1'b0, 1'b1);
        check_frame("b2b_3c", 16'h0278, 10, 9, 8'hFF, 1'b0);
        check_frame("b2b_ff", 16'h03FE, 10, -1, 8'h00, 1'b1);

        // Request during data bit 3 of 0x55 (even parity) is ignored
        start_req(8'h55, 1'b1, 1'b0, 1'b0);
        check_frame("ign_55", 16'h04AA, 11, 4, 8'h00, 1'b1);
        @(negedge CLK);
        check("ign_noextra_tx", 32'(TX_OUT), 32'd1);
        check("ign_noextra_busy", 32'(Busy), 32'd0);

        // Asynchronous reset during data bit 5 (edge e6)
        start_req(8'hA5, 1'b1, 1'b0, 1'b0);
        check_frame("rst_mid", 16'h054A, 7, -1, 8'h00, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_tx", 32'(TX_OUT), 32'd1);
        check("rst_async_busy", 32'(Busy), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check("rst_hold_tx", 32'(TX_OUT), 32'd1);
        RST = 1'b0;
        start_req(8'hA5, 1'b1, 1'b0, 1'b0);
        check_frame("post_rst", 16'h054A, 11, -1, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
